// File: rtl/vram_rect_writer.sv
// Rectangle-fill write engine for the VGA frame buffer: takes a clipped
// rectangle + colour from the host and streams one pixel write per cycle.
module vram_rect_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [8:0]  cmd_y0,
    input  logic [9:0]  cmd_x1,
    input  logic [8:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    input  logic        stall,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  x0c_q, x0c_d;
    logic [9:0]  x1c_q, x1c_d;
    logic [8:0]  y1c_q, y1c_d;
    logic [11:0] color_q, color_d;

    logic        wr_en_q, wr_en_d;
    logic [18:0] wr_addr_q, wr_addr_d;
    logic [11:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic [9:0]  cx0, cx1;
    logic [8:0]  cy0, cy1;
    logic        empty;

    // Clip at accept time so the fill loop never leaves the visible area.
    always_comb begin
        cx0   = (cmd_x0 > X_MAX) ? X_MAX : cmd_x0;
        cx1   = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        cy0   = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
        cy1   = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        empty = (cx0 > cx1) || (cy0 > cy1);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0c_d   = x0c_q;
        x1c_d   = x1c_q;
        y1c_d   = y1c_q;
        color_d = color_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    x_d     = cx0;
                    y_d     = cy0;
                    x0c_d   = cx0;
                    x1c_d   = cx1;
                    y1c_d   = cy1;
                    color_d = cmd_color;
                    state_d = empty ? DONE : FILL;
                end
            end
            FILL: begin
                // Compare before increment so x/y never wrap at the port width.
                if (!stall) begin
                    if (x_q < x1c_q) begin
                        x_d = x_q + 10'd1;
                    end else if (y_q < y1c_q) begin
                        x_d = x0c_q;
                        y_d = y_q + 9'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        wr_en_d     = (state_d == FILL);
        wr_addr_d   = (state_d == FILL) ? {x_d, y_d} : 19'd0;
        wr_data_d   = (state_d == FILL) ? color_d : 12'd0;
        busy_d      = (state_d == FILL);
        done_d      = (state_d == DONE);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x0c_q       <= '0;
            x1c_q       <= '0;
            y1c_q       <= '0;
            color_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x0c_q       <= x0c_d;
            x1c_q       <= x1c_d;
            y1c_q       <= y1c_d;
            color_q     <= color_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Directed bench for vram_rect_writer: a queue-based pixel-list model checked
// every cycle, plus literal latency/count expectations per command.
module tb_vram_rect_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_x1;
    logic [8:0]  cmd_y0, cmd_y1;
    logic [11:0] cmd_color;
    logic        stall;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    vram_rect_writer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model state: pending pixel writes {addr, data} and the cycle done is due.
    logic [30:0] exp_q[$];
    int done_due = -1;
    int hs_cyc = -1;
    int done_cyc = -1;
    int wr_cnt = 0;
    int wr_cyc = 0;
    bit first_pend = 0;
    logic [18:0] first_addr;
    logic [11:0] first_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Capture accepted commands and expand them into the expected pixel list.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            done_due = -1;
        end else if (chk_en && cmd_valid && cmd_ready) begin
            int x0, x1, y0, y1;
            chk("accept_while_idle", exp_q.size(), 0);
            x0 = (cmd_x0 > 639) ? 639 : int'(cmd_x0);
            x1 = (cmd_x1 > 639) ? 639 : int'(cmd_x1);
            y0 = (cmd_y0 > 479) ? 479 : int'(cmd_y0);
            y1 = (cmd_y1 > 479) ? 479 : int'(cmd_y1);
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++)
                    exp_q.push_back({10'(x), 9'(y), cmd_color});
            hs_cyc = cyc;
            wr_cnt = 0;
            wr_cyc = 0;
            first_pend = 1;
            if (exp_q.size() == 0) done_due = cyc + 1;
        end
        cyc = cyc + 1;
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit filling;
            bit done_now;
            filling  = (exp_q.size() > 0);
            done_now = (cyc == done_due);
            chk("wr_en", wr_en, filling);
            chk("busy", busy, filling);
            chk("done", done, done_now);
            chk("cmd_ready", cmd_ready, !filling && !done_now);
            if (wr_en && filling) begin
                chk("wr_addr", wr_addr, exp_q[0][30:12]);
                chk("wr_data", wr_data, exp_q[0][11:0]);
                wr_cyc++;
                if (first_pend) begin
                    first_addr = wr_addr;
                    first_data = wr_data;
                    first_pend = 0;
                end
                if (!stall) begin
                    void'(exp_q.pop_front());
                    wr_cnt++;
                    if (exp_q.size() == 0) done_due = cyc + 1;
                end
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                            input logic [9:0] x1, input logic [8:0] y1,
                            input logic [11:0] col, input bit keep_valid);
        bit rdy;
        int n;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
        cmd_color = col;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 3000);
        if (!rdy) chk("handshake_timeout", 0, 1);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 3000);
        if (!cmd_ready) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        cmd_color = '0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk_en = 1;

        // Single pixel
        send_cmd(10'd5, 9'd7, 10'd5, 9'd7, 12'hF00, 0);
        wait_idle();
        chk("single_nwr", wr_cnt, 1);
        chk("single_addr", first_addr, 19'h00A07);
        chk("single_data", first_data, 12'hF00);
        chk("single_done_lat", done_cyc - hs_cyc, 2);

        // 3x2 fill
        send_cmd(10'd10, 9'd20, 10'd12, 9'd21, 12'h0F0, 0);
        wait_idle();
        chk("fill_nwr", wr_cnt, 6);
        chk("fill_wrcyc", wr_cyc, 6);
        chk("fill_first", first_addr, {10'd10, 9'd20});
        chk("fill_done_lat", done_cyc - hs_cyc, 7);

        // Same fill, 3 stall cycles on the second write
        send_cmd(10'd10, 9'd20, 10'd12, 9'd21, 12'h0F0, 0);
        @(posedge clk); #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        wait_idle();
        chk("stall_nwr", wr_cnt, 6);
        chk("stall_wrcyc", wr_cyc, 9);
        chk("stall_done_lat", done_cyc - hs_cyc, 10);

        // Clipping to the bottom-right corner
        send_cmd(10'd638, 9'd479, 10'd1000, 9'd511, 12'h00F, 0);
        wait_idle();
        chk("clip_nwr", wr_cnt, 2);
        chk("clip_first", first_addr, {10'd638, 9'd479});
        chk("clip_done_lat", done_cyc - hs_cyc, 3);

        // Empty rectangle
        send_cmd(10'd50, 9'd5, 10'd40, 9'd9, 12'h123, 0);
        wait_idle();
        chk("empty_nwr", wr_cnt, 0);
        chk("empty_done_lat", done_cyc - hs_cyc, 1);

        // Reset during the fourth write of a 10x10 fill
        send_cmd(10'd0, 9'd0, 10'd9, 9'd9, 12'hABC, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        dc = done_cyc;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_nwr", wr_cnt, 4);
        repeat (20) @(negedge clk);
        chk("rstmid_no_done", done_cyc, dc);

        // Normal command after reset
        @(posedge clk); #1;
        send_cmd(10'd100, 9'd200, 10'd101, 9'd201, 12'h555, 0);
        wait_idle();
        chk("post_rst_nwr", wr_cnt, 4);
        chk("post_rst_lat", done_cyc - hs_cyc, 5);

        // Back-to-back with cmd_valid held high
        send_cmd(10'd1, 9'd1, 10'd3, 9'd1, 12'h111, 1);
        dc = hs_cyc;
        send_cmd(10'd7, 9'd2, 10'd7, 9'd3, 12'h222, 0);
        chk("b2b_gap", hs_cyc - dc, 5);
        wait_idle();
        chk("b2b_nwr2", wr_cnt, 2);
        chk("b2b_first2", first_addr, {10'd7, 9'd2});

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
- Write-side engine for the video memory that the VGA display path reads.
- Accepts rectangle-fill commands from a host over a valid/ready handshake.
- Emits one pixel write per cycle into the VRAM write port, using the display path's address layout {x[9:0], y[8:0]} and 12-bit RGB444 data.
- Sits between the host (keyboard/CPU logic) and the VRAM write port; the display side is unaffected.

Parameters:
- H_RES, 640, visible width; x coordinates clipped to H_RES-1.
- V_RES, 480, visible height; y coordinates clipped to V_RES-1.

Ports:
- clk  in  1  system clock (VRAM write-port clock).
- rst  in  1  synchronous reset, active-low.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  10  left column, inclusive.
- cmd_y0  in  9  top row, inclusive.
- cmd_x1  in  10  right column, inclusive.
- cmd_y1  in  9  bottom row, inclusive.
- cmd_color  in  12  fill colour {r[3:0], g[3:0], b[3:0]}.
- stall  in  1  VRAM port busy; hold the current write.
- wr_en  out  1  VRAM write strobe.
- wr_addr  out  19  VRAM address {x[9:0], y[8:0]}.
- wr_data  out  12  VRAM write data.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cmd_ready=1 from the following cycle.
  - An in-flight fill is abandoned: no further writes, and no done pulse.
- States:
  - IDLE: cmd_ready=1. A handshake occurs when cmd_valid&&cmd_ready at an edge. At that edge the engine latches the clipped coordinates and colour and goes to FILL, or to DONE if the rectangle is empty. Registers x=x0c and y=y0c.
  - FILL: cmd_ready=0, busy=1. Each cycle, wr_en=1, wr_addr={x,y}, wr_data=colour.
    - If stall=1 at an edge: x, y and the outputs hold, and wr_en stays 1. The same write is presented again.
    - If stall=0 at an edge, the write is considered performed. The engine then advances row-major: x inner, y outer.
      - If x<x1c: x=x+1.
      - Else if y<y1c: x=x0c, y=y+1.
      - Else: go to DONE.
  - DONE: lasts one cycle. done=1, wr_en=0, busy=0, cmd_ready=0. Next state is IDLE.
- Outputs are registered. The first write is visible the cycle after the handshake.
- Latency: N=(x1c-x0c+1)*(y1c-y0c+1) writes take N unstalled cycles. done is asserted in cycle N+1 after the handshake, and cmd_ready is back in cycle N+2.
- Clipping is applied at accept time: x0c=min(x0,H_RES-1), x1c=min(x1,H_RES-1), y0c=min(y0,V_RES-1), y1c=min(y1,V_RES-1).
- Empty rectangle (x0c>x1c or y0c>y1c): zero writes. The engine goes IMMEDIATELY from IDLE to DONE, so done is asserted the cycle after the handshake.
- Coordinate arithmetic is unsigned at the port widths. Increment never wraps, because the comparison against x1c/y1c precedes it.
- wr_addr is the plain concatenation; y occupies the low 9 bits.
- stall is ignored outside FILL.
- cmd_valid while not ready is ignored; the host must hold its command until ready.

Test Plan:
- Single pixel: x0=x1=5, y0=y1=7, colour 0xF00, stall=0.
  - Exactly one wr_en cycle at T+1 with wr_addr={10'd5,9'd7}=0x00A07 and wr_data=0xF00.
  - done at T+2; cmd_ready=1 at T+3.
- 3x2 fill: x 10..12, y 20..21, colour 0x0F0.
  - Six writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21).
  - done pulse of exactly one cycle.
- Stall: the same 3x2 fill with stall=1 for 3 cycles during the second write.
  - Address (11,20) is held for 4 cycles with wr_en=1.
  - Total 6 distinct addresses, none duplicated after stall drops; done 3 cycles later than the unstalled case.
- Clipping and empty rectangles:
  - x0=638, x1=1000, y0=479, y1=511 → writes only (638,479) and (639,479).
  - x0=50, x1=40 → zero writes and done at T+1.
- Reset mid-fill: rst=0 during the fourth write of a 10x10 fill.
  - wr_en=0, busy=0, done=0 the cycle after; no done pulse ever appears.
  - A new command after reset executes normally.
- Back-to-back: cmd_valid held high with two commands.
  - The second is accepted only when cmd_ready returns, i.e. N+2 cycles after the first handshake.
  - No write overlap between the two commands.
